// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: DIFF = A - B - BORROW_IN, one bit per clock, LSB first.
// One full-subtractor cell plus a borrow flop, with a start/busy/done handshake.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             BORROW_IN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] DIFF,
    output logic             BORROW_OUT
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bf_q, bf_d;
    logic             bout_q, bout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             d_bit;
    logic             b_next;

    // Full-subtractor cell on the current LSBs and the stored borrow.
    always_comb begin
        d_bit  = a_q[0] ^ b_q[0] ^ bf_q;
        b_next = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bf_q);
    end

    // Next-state logic; results only move to DIFF/BORROW_OUT on the last bit.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        bf_d    = bf_q;
        bout_d  = bout_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (START) begin
                    a_d     = A;
                    b_d     = B;
                    bf_d    = BORROW_IN;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = {d_bit, res_q[WIDTH-1:1]};
                bf_d  = b_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    diff_d  = {d_bit, res_q[WIDTH-1:1]};
                    bout_d  = b_next;
                    done_d  = 1'b1;
                    state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; synchronous reset aborts any operation.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            bf_q    <= 1'b0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            bf_q    <= bf_d;
            bout_q  <= bout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign BUSY       = busy_q;
    assign DONE       = done_q;
    assign DIFF       = diff_q;
    assign BORROW_OUT = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=8 and WIDTH=16.
// Inputs change and outputs are sampled on the falling edge.
module tb_serial_subtractor;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;

    logic        START8 = 1'b0;
    logic [7:0]  A8 = '0;
    logic [7:0]  B8 = '0;
    logic        BIN8 = 1'b0;
    logic        BUSY8, DONE8, BOUT8;
    logic [7:0]  DIFF8;

    logic        START16 = 1'b0;
    logic [15:0] A16 = '0;
    logic [15:0] B16 = '0;
    logic        BIN16 = 1'b0;
    logic        BUSY16, DONE16, BOUT16;
    logic [15:0] DIFF16;

    int checks = 0;
    int failures = 0;
    logic [15:0] last8 = '0;
    logic [15:0] last16 = '0;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .CLK(CLK), .RST(RST), .START(START8),
        .A(A8), .B(B8), .BORROW_IN(BIN8),
        .BUSY(BUSY8), .DONE(DONE8),
        .DIFF(DIFF8), .BORROW_OUT(BOUT8)
    );

    serial_subtractor #(.WIDTH(16)) dut16 (
        .CLK(CLK), .RST(RST), .START(START16),
        .A(A16), .B(B16), .BORROW_IN(BIN16),
        .BUSY(BUSY16), .DONE(DONE16),
        .DIFF(DIFF16), .BORROW_OUT(BOUT16)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full transaction; optionally pulses START with other operands mid-SHIFT.
    task automatic run(input bit wide, input logic [15:0] a,
                       input logic [15:0] b, input logic bin,
                       input logic [15:0] ed, input logic eb,
                       input bit inj);
        int w;
        logic [15:0] prev;
        w = wide ? 16 : 8;
        prev = wide ? last16 : last8;
        if (wide) begin
            A16 = a; B16 = b; BIN16 = bin; START16 = 1'b1;
        end else begin
            A8 = a[7:0]; B8 = b[7:0]; BIN8 = bin; START8 = 1'b1;
        end
        @(posedge CLK);
        @(negedge CLK);
        START8 = 1'b0;
        START16 = 1'b0;
        chk("busy_k", wide ? BUSY16 : BUSY8, 1);
        chk("done_k", wide ? DONE16 : DONE8, 0);
        for (int j = 1; j <= w; j++) begin
            @(negedge CLK);
            chk("done_j", wide ? DONE16 : DONE8, (j == w) ? 1 : 0);
            chk("busy_j", wide ? BUSY16 : BUSY8, 1);
            if (j < w) begin
                chk("diff_hold", wide ? DIFF16 : {8'h0, DIFF8}, prev);
            end else begin
                chk("diff", wide ? DIFF16 : {8'h0, DIFF8}, ed);
                chk("bout", wide ? BOUT16 : BOUT8, eb);
            end
            if (j == 1) begin
                A8 = 8'hAA; B8 = 8'h55; BIN8 = ~bin;
                A16 = 16'hAAAA; B16 = 16'h5555; BIN16 = ~bin;
            end
            if (inj && (j == 2 || j == 4)) begin
                A8 = 8'h00; B8 = 8'hFF; BIN8 = 1'b1; START8 = 1'b1;
            end else begin
                START8 = 1'b0;
            end
        end
        START8 = 1'b0;
        @(negedge CLK);
        chk("busy_end", wide ? BUSY16 : BUSY8, 0);
        chk("done_end", wide ? DONE16 : DONE8, 0);
        chk("diff_end", wide ? DIFF16 : {8'h0, DIFF8}, ed);
        if (wide) last16 = ed;
        else last8 = ed;
    endtask

    task automatic rnd(input bit wide);
        logic [15:0] a, b;
        logic bin;
        logic [16:0] r;
        a = 16'($urandom);
        b = 16'($urandom);
        bin = 1'($urandom);
        if (!wide) begin
            a[15:8] = '0;
            b[15:8] = '0;
        end
        r = {1'b0, a} - {1'b0, b} - {16'h0, bin};
        if (wide) run(1, a, b, bin, r[15:0], r[16], 0);
        else run(0, a, b, bin, {8'h0, r[7:0]}, r[16], 0);
    endtask

    initial begin
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        chk("rst_busy8", BUSY8, 0);
        chk("rst_done8", DONE8, 0);
        chk("rst_diff8", DIFF8, 0);
        chk("rst_bout8", BOUT8, 0);
        chk("rst_busy16", BUSY16, 0);
        chk("rst_diff16", DIFF16, 0);
        RST = 1'b0;
        @(negedge CLK);

        run(0, 16'h03, 16'h02, 0, 16'h01, 0, 0);
        run(0, 16'h02, 16'h03, 1, 16'hFE, 1, 0);
        run(0, 16'hFF, 16'h02, 0, 16'hFD, 0, 0);
        run(0, 16'h00, 16'h00, 1, 16'hFF, 1, 0);
        run(0, 16'h10, 16'h10, 0, 16'h00, 0, 0);
        run(0, 16'h10, 16'h0F, 1, 16'h00, 0, 0);
        run(0, 16'h10, 16'h10, 1, 16'hFF, 1, 0);

        run(0, 16'h5A, 16'h3C, 0, 16'h1E, 0, 1);
        repeat (3) begin
            @(negedge CLK);
            chk("no_extra_done", DONE8, 0);
            chk("no_extra_busy", BUSY8, 0);
        end

        A8 = 8'h77; B8 = 8'h11; BIN8 = 1'b0; START8 = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        START8 = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk("abort_busy", BUSY8, 0);
        chk("abort_done", DONE8, 0);
        chk("abort_diff", DIFF8, 0);
        chk("abort_bout", BOUT8, 0);
        RST = 1'b0;
        last8 = '0;
        last16 = '0;
        repeat (10) begin
            @(negedge CLK);
            chk("abort_nodone", DONE8, 0);
        end
        run(0, 16'h80, 16'h01, 1, 16'h7E, 0, 0);

        run(1, 16'h0001, 16'h0002, 0, 16'hFFFF, 1, 0);
        run(1, 16'h1234, 16'h0234, 1, 16'h0FFF, 0, 0);

        repeat (6) rnd(0);
        repeat (6) rnd(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
